// File: rtl/i2c_target_regfile.sv
// I2C 7-bit-address target with an 8-bit register file and a local SoC register port.
// Latency: SCL/SDA seen 2 aclk after the pad (+3 with glitch filter); loc_rdata 1 aclk after loc_addr.
// Backpressure: none; the I2C master paces all transfers, and the local port is always ready.
//
// Ports:
//   aclk, aresetn         system clock, asynchronous active-low reset
//   SCL_I, SDA_I          pad inputs (open-drain bus)
//   SDA_O, SDA_T          SDA output value (always 0) and tristate (0 = drive low, 1 = release)
//   loc_addr/we/wdata     local register write port; loc_rdata = regs[loc_addr], registered
//   wr_strobe, wr_addr    one pulse per byte written over I2C, with its register index
//   busy                  high from address match until STOP, master NACK or address mismatch
// Build option: define I2C_TARGET_GLITCH_FILTER_EN to add a 3-cycle persistence filter
// on both synchronized lines.

module i2c_target_regfile #(
  parameter logic [6:0] P_I2C_DEV_ADDR = 7'h41,
  parameter int         P_NUM_REGS     = 16,
  parameter int         P_AW           = $clog2(P_NUM_REGS)
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            SCL_I,
  input  logic            SDA_I,
  output logic            SDA_O,
  output logic            SDA_T,
  input  logic [P_AW-1:0] loc_addr,
  input  logic            loc_we,
  input  logic [7:0]      loc_wdata,
  output logic [7:0]      loc_rdata,
  output logic            wr_strobe,
  output logic [P_AW-1:0] wr_addr,
  output logic            busy
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_MACK,
    ST_WAIT
  } state_t;

  // ------------------------------------------------------------------
  // Input conditioning
  // ------------------------------------------------------------------
  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_c;
  logic       sda_c;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], SCL_I};
      sda_sync_q <= {sda_sync_q[0], SDA_I};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  // Bit 0 = SCL, bit 1 = SDA. The filtered value follows the input only once
  // the input has differed from it on 3 consecutive samples.
  logic [1:0] raw_lines;
  logic [1:0] filt_q;
  logic [1:0] filt_d;
  logic [1:0] fcnt_q [2];
  logic [1:0] fcnt_d [2];

  assign raw_lines = {sda_sync_q[1], scl_sync_q[1]};

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = 2'd0;
      if (raw_lines[i] != filt_q[i]) begin
        if (fcnt_q[i] == 2'd2) begin
          filt_d[i] = raw_lines[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      filt_q <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        fcnt_q[i] <= 2'd0;
      end
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign scl_c = filt_q[0];
  assign sda_c = filt_q[1];
`else
  assign scl_c = scl_sync_q[1];
  assign sda_c = sda_sync_q[1];
`endif

  logic scl_d_q;
  logic sda_d_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      scl_d_q <= 1'b1;
      sda_d_q <= 1'b1;
    end else begin
      scl_d_q <= scl_c;
      sda_d_q <= sda_c;
    end
  end

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  assign scl_rise  = scl_c & ~scl_d_q;
  assign scl_fall  = ~scl_c & scl_d_q;
  // SCL must be high on both samples so an SDA change near an SCL edge is not
  // mistaken for START/STOP.
  assign start_det = scl_c & scl_d_q & sda_d_q & ~sda_c;
  assign stop_det  = scl_c & scl_d_q & ~sda_d_q & sda_c;

  // ------------------------------------------------------------------
  // Protocol FSM
  // ------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;   // 8 means a full byte has been shifted
  logic [7:0]      shreg_q, shreg_d;
  logic [P_AW-1:0] ptr_q, ptr_d;
  logic [P_AW-1:0] ptr_inc;
  logic            rw_q, rw_d;
  logic            sda_t_q, sda_t_d;
  logic            busy_q, busy_d;
  logic            wr_strobe_q, wr_strobe_d;
  logic [P_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]      regs_q [P_NUM_REGS];
  logic [7:0]      regs_d [P_NUM_REGS];
  logic [7:0]      rd_byte;

  assign ptr_inc = ptr_q + P_AW'(1);
  assign rd_byte = regs_q[ptr_q];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_t_d     = sda_t_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;

    if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      sda_t_d   = 1'b1;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_t_d   = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise && !bit_cnt_q[3]) begin
            shreg_d   = {shreg_q[6:0], sda_c};
            bit_cnt_d = bit_cnt_q + 4'd1;
            // The byte is committed to the register file during the strobe
            // cycle; the pointer advances now so wr_addr keeps the old index.
            if (state_q == ST_WDATA && bit_cnt_q == 4'd7) begin
              wr_strobe_d = 1'b1;
              wr_addr_d   = ptr_q;
              ptr_d       = ptr_inc;
            end
          end else if (scl_fall && bit_cnt_q[3]) begin
            bit_cnt_d = 4'd0;
            if (state_q == ST_ADDR) begin
              if (shreg_q[7:1] == P_I2C_DEV_ADDR) begin
                state_d = ST_ADDR_ACK;
                rw_d    = shreg_q[0];
                busy_d  = 1'b1;
                sda_t_d = 1'b0;
              end else begin
                state_d = ST_WAIT;
                busy_d  = 1'b0;
              end
            end else if (state_q == ST_PTR) begin
              ptr_d   = shreg_q[P_AW-1:0];
              state_d = ST_PTR_ACK;
              sda_t_d = 1'b0;
            end else begin
              state_d = ST_WDATA_ACK;
              sda_t_d = 1'b0;
            end
          end
        end

        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            sda_t_d   = 1'b1;
            if (state_q == ST_ADDR_ACK && rw_q) begin
              // First read bit goes on the bus as the ACK clock ends.
              state_d = ST_RDATA;
              shreg_d = rd_byte;
              sda_t_d = rd_byte[7];
            end else if (state_q == ST_ADDR_ACK) begin
              state_d = ST_PTR;
            end else begin
              state_d = ST_WDATA;
            end
          end
        end

        ST_RDATA: begin
          if (scl_rise && !bit_cnt_q[3]) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            if (bit_cnt_q[3]) begin
              state_d = ST_RDATA_MACK;
              sda_t_d = 1'b1;
            end else begin
              shreg_d = shreg_q << 1;
              sda_t_d = shreg_q[6];
            end
          end
        end

        ST_RDATA_MACK: begin
          if (scl_rise) begin
            if (sda_c) begin
              state_d = ST_WAIT;
              busy_d  = 1'b0;
            end else begin
              ptr_d   = ptr_inc;
              shreg_d = regs_q[ptr_inc];
            end
          end else if (scl_fall) begin
            // Only reachable after a master ACK; a NACK has already left.
            state_d   = ST_RDATA;
            bit_cnt_d = 4'd0;
            sda_t_d   = shreg_q[7];
          end
        end

        ST_WAIT: sda_t_d = 1'b1;

        default: sda_t_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shreg_q     <= 8'h00;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_t_q     <= 1'b1;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_t_q     <= sda_t_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  // ------------------------------------------------------------------
  // Register file; an I2C write beats a local write to the same index.
  // shreg_q still holds the received byte throughout the strobe cycle.
  // ------------------------------------------------------------------
  logic [7:0] loc_rdata_q;

  always_comb begin
    for (int i = 0; i < P_NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_strobe_q && wr_addr_q == P_AW'(i)) begin
        regs_d[i] = shreg_q;
      end else if (loc_we && loc_addr == P_AW'(i)) begin
        regs_d[i] = loc_wdata;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < P_NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
      loc_rdata_q <= 8'h00;
    end else begin
      regs_q      <= regs_d;
      loc_rdata_q <= regs_q[loc_addr];
    end
  end

  assign SDA_O     = 1'b0;
  assign SDA_T     = sda_t_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign loc_rdata = loc_rdata_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
`timescale 1ns/1ps
module tb_i2c_target_regfile;

  localparam int Q = 625;  // quarter of a 400 kHz SCL period

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       scl_m;
  logic       sda_m;
  wire        sda_line;
  logic       sda_o;
  logic       sda_t;
  logic [3:0] loc_addr;
  logic       loc_we;
  logic [7:0] loc_wdata;
  logic [7:0] loc_rdata;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [3:0] strobe_q[$];

  always #50 aclk = ~aclk;  // 10 MHz

  // Open-drain bus: master and target can only pull low.
  assign sda_line = sda_m & (sda_t | sda_o);

  i2c_target_regfile dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .SCL_I     (scl_m),
    .SDA_I     (sda_line),
    .SDA_O     (sda_o),
    .SDA_T     (sda_t),
    .loc_addr  (loc_addr),
    .loc_we    (loc_we),
    .loc_wdata (loc_wdata),
    .loc_rdata (loc_rdata),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .busy      (busy)
  );

  always @(negedge aclk) begin
    if (aresetn && wr_strobe) strobe_q.push_back(wr_addr);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bus master primitives ----------------
  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic xfer_bit(input logic b, input logic glitch, output logic s);
    sda_m = b; #Q;
    scl_m = 1'b1; #Q;
    s = sda_line;
    if (glitch) begin
      #200; scl_m = 1'b0; #100; scl_m = 1'b1; #(Q - 300);
    end else begin
      #Q;
    end
    scl_m = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], (i == glitch_bit), s);
    xfer_bit(1'b1, 1'b0, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    xfer_bit(mack, 1'b0, s);
  endtask

  task automatic loc_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge aclk) loc_addr = a;
    @(posedge aclk); #1;
    d = loc_rdata;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    aresetn = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    loc_addr = 4'd0; loc_we = 1'b0; loc_wdata = 8'h00;
    repeat (3) @(posedge aclk); #1;
    checks++; if (sda_t !== 1'b1) begin errors++; $display("FAIL reset_sda_t got %b want 1", sda_t); end
    checks++; if (sda_o !== 1'b0) begin errors++; $display("FAIL reset_sda_o got %b want 0", sda_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_wr_strobe got %b want 0", wr_strobe); end
    checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
    checks++; if (loc_rdata !== 8'h00) begin errors++; $display("FAIL reset_loc_rdata got %h want 00", loc_rdata); end
    @(negedge aclk) aresetn = 1'b1;
    repeat (5) @(posedge aclk);
  endtask

  task automatic test_burst_write();
    logic a0, a1, a2, a3;
    logic [7:0] d;
    strobe_q.delete();
    i2c_start();
    send_byte(8'h82, -1, a0);
    send_byte(8'h03, -1, a1);
    send_byte(8'hA5, -1, a2);
    send_byte(8'h5A, -1, a3);
    checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL bw_acks got %b want 0000", {a0, a1, a2, a3}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bw_busy_active got %b want 1", busy); end
    i2c_stop();
    repeat (4) @(posedge aclk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bw_busy_after_stop got %b want 0", busy); end
    checks++; if (strobe_q.size() !== 2) begin errors++; $display("FAIL bw_strobe_count got %0d want 2", strobe_q.size()); end
    if (strobe_q.size() == 2) begin
      checks++; if (strobe_q[0] !== 4'd3) begin errors++; $display("FAIL bw_strobe0_addr got %0d want 3", strobe_q[0]); end
      checks++; if (strobe_q[1] !== 4'd4) begin errors++; $display("FAIL bw_strobe1_addr got %0d want 4", strobe_q[1]); end
    end
    loc_read(4'd3, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL bw_reg3 got %h want a5", d); end
    loc_read(4'd4, d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL bw_reg4 got %h want 5a", d); end
  endtask

  task automatic test_burst_read();
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    strobe_q.delete();
    i2c_start();
    send_byte(8'h82, -1, a0);
    send_byte(8'h03, -1, a1);
    i2c_start();
    send_byte(8'h83, -1, a2);
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rd_acks got %b want 000", {a0, a1, a2}); end
    recv_byte(1'b0, d0);
    recv_byte(1'b1, d1);
    checks++; if (d0 !== 8'hA5) begin errors++; $display("FAIL rd_byte0 got %h want a5", d0); end
    checks++; if (d1 !== 8'h5A) begin errors++; $display("FAIL rd_byte1 got %h want 5a", d1); end
    checks++; if (sda_t !== 1'b1) begin errors++; $display("FAIL rd_sda_t_after_nack got %b want 1", sda_t); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_after_nack got %b want 0", busy); end
    i2c_stop();
    repeat (4) @(posedge aclk); #1;
    checks++; if (strobe_q.size() !== 0) begin errors++; $display("FAIL rd_no_strobe got %0d want 0", strobe_q.size()); end
  endtask

  task automatic test_addr_mismatch();
    logic a0;
    logic [7:0] d;
    strobe_q.delete();
    i2c_start();
    send_byte(8'h88, -1, a0);
    checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL mm_ninth_clock_sda got %b want 1", a0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mm_busy got %b want 0", busy); end
    send_byte(8'h03, -1, a0);
    i2c_stop();
    repeat (4) @(posedge aclk); #1;
    checks++; if (strobe_q.size() !== 0) begin errors++; $display("FAIL mm_no_strobe got %0d want 0", strobe_q.size()); end
    loc_read(4'd3, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL mm_reg3_unchanged got %h want a5", d); end
  endtask

  task automatic test_ptr_wrap();
    logic a0, a1, a2, a3, a4;
    logic [7:0] d;
    strobe_q.delete();
    i2c_start();
    send_byte(8'h82, -1, a0);
    send_byte(8'h0F, -1, a1);
    send_byte(8'h11, -1, a2);
    send_byte(8'h22, -1, a3);
    send_byte(8'h33, -1, a4);
    i2c_stop();
    checks++; if ({a0, a1, a2, a3, a4} !== 5'b0) begin errors++; $display("FAIL wrap_acks got %b want 00000", {a0, a1, a2, a3, a4}); end
    checks++; if (strobe_q.size() !== 3) begin errors++; $display("FAIL wrap_strobe_count got %0d want 3", strobe_q.size()); end
    if (strobe_q.size() == 3) begin
      checks++; if ({strobe_q[0], strobe_q[1], strobe_q[2]} !== {4'd15, 4'd0, 4'd1}) begin
        errors++; $display("FAIL wrap_strobe_addrs got %0d %0d %0d want 15 0 1", strobe_q[0], strobe_q[1], strobe_q[2]);
      end
    end
    loc_read(4'd15, d);
    checks++; if (d !== 8'h11) begin errors++; $display("FAIL wrap_reg15 got %h want 11", d); end
    loc_read(4'd0, d);
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL wrap_reg0 got %h want 22", d); end
    loc_read(4'd1, d);
    checks++; if (d !== 8'h33) begin errors++; $display("FAIL wrap_reg1 got %h want 33", d); end
    // Upper pointer bits are ignored: 0x2F selects index 15.
    i2c_start();
    send_byte(8'h82, -1, a0);
    send_byte(8'h2F, -1, a1);
    send_byte(8'h44, -1, a2);
    i2c_stop();
    loc_read(4'd15, d);
    checks++; if (d !== 8'h44) begin errors++; $display("FAIL wrap_ptr_2f_reg15 got %h want 44", d); end
  endtask

  task automatic test_local_conflict();
    logic a0, a1, a2;
    logic seen;
    logic [7:0] d;
    i2c_start();
    send_byte(8'h82, -1, a0);
    send_byte(8'h05, -1, a1);
    seen = 1'b0;
    fork
      send_byte(8'h77, -1, a2);
      begin
        for (int k = 0; k < 400 && !seen; k++) begin
          @(posedge aclk); #1;
          if (wr_strobe) seen = 1'b1;
        end
        if (seen) begin
          loc_addr = 4'd5; loc_wdata = 8'hEE; loc_we = 1'b1;
          @(posedge aclk); #1;
          loc_we = 1'b0;
        end
      end
    join
    i2c_stop();
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL lc_strobe_seen got %b want 1 (timeout)", seen); end
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL lc_acks got %b want 000", {a0, a1, a2}); end
    loc_read(4'd5, d);
    checks++; if (d !== 8'h77) begin errors++; $display("FAIL lc_reg5_i2c_wins got %h want 77", d); end
    @(negedge aclk) begin loc_addr = 4'd6; loc_wdata = 8'h3C; loc_we = 1'b1; end
    @(negedge aclk) loc_we = 1'b0;
    loc_read(4'd6, d);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL lc_local_write_reg6 got %h want 3c", d); end
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2;
    logic [7:0] d;
    i2c_start();
    send_byte(8'h82, -1, a0);
    send_byte(8'h08, -1, a1);
    i2c_start();
    send_byte(8'h83, -1, a2);
    // regs[8] = 0x00, so the target is now driving its first bit low.
    checks++; if (sda_t !== 1'b0) begin errors++; $display("FAIL rst_pre_drive_low got %b want 0", sda_t); end
    @(negedge aclk) aresetn = 1'b0;
    #1;
    checks++; if (sda_t !== 1'b1) begin errors++; $display("FAIL rst_sda_release got %b want 1", sda_t); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk) aresetn = 1'b1;
    repeat (10) @(posedge aclk);
    i2c_start();
    send_byte(8'h82, -1, a0);
    send_byte(8'h02, -1, a1);
    send_byte(8'h9C, -1, a2);
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rst_next_acks got %b want 000", {a0, a1, a2}); end
    loc_read(4'd2, d);
    checks++; if (d !== 8'h9C) begin errors++; $display("FAIL rst_reg2 got %h want 9c", d); end
    loc_read(4'd3, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_reg3_cleared got %h want 00", d); end
  endtask

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic a0, a1, a2;
    logic [7:0] d;
    strobe_q.delete();
    i2c_start();
    send_byte(8'h82, -1, a0);
    send_byte(8'h0A, -1, a1);
    send_byte(8'hC3, 3, a2);
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL gl_acks got %b want 000", {a0, a1, a2}); end
    loc_read(4'd10, d);
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL gl_reg10 got %h want c3", d); end
    checks++; if (strobe_q.size() !== 1) begin errors++; $display("FAIL gl_strobe_count got %0d want 1", strobe_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_burst_write();
    test_burst_read();
    test_addr_mismatch();
    test_ptr_wrap();
    test_local_conflict();
    test_reset_mid_read();
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
